// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: default memory widths,
// memory-select codes and the layer-memory arbiter state encoding.
package conv_pkg;
   localparam int AW_DEF = 12;
   localparam int DW_DEF = 20;

   localparam logic [2:0] CSEL_NONE = 3'b000;
   localparam logic [2:0] CSEL_L0   = 3'b001;
   localparam logic [2:0] CSEL_L1   = 3'b011;

   typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t;
endpackage

// File: rtl/layer_mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit searching upward
// from last+1 (wrapping), returned both one-hot and as an index.
module rr_picker #(
   parameter int NUM_REQ = 3,
   parameter int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      last,
   output logic [NUM_REQ-1:0] win,
   output logic [IW-1:0]      win_idx
);
   logic [IW-1:0] cand;
   logic          found;

   // last itself is tried last, so a re-requesting previous owner yields to others
   always_comb begin
      win     = '0;
      win_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = IW'((int'(last) + i) % NUM_REQ);
         if (!found && req[cand]) begin
            found     = 1'b1;
            win[cand] = 1'b1;
            win_idx   = cand;
         end
      end
   end
endmodule

// File: rtl/layer_mem_arbiter.sv
// Round-robin owner arbitration for the single layer-memory port, with read
// returns routed to the issuer. LAYER_MEM_ARB_TIMEOUT_EN adds a forced release.
module layer_mem_arbiter
   import conv_pkg::*;
#(
   parameter int NUM_REQ  = 3,
   parameter int AW       = AW_DEF,
   parameter int DW       = DW_DEF,
   parameter int HOLD_MAX = 4096
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ-1:0]    req_wr,
   input  logic [NUM_REQ-1:0]    req_rd,
   input  logic [NUM_REQ*AW-1:0] req_waddr,
   input  logic [NUM_REQ*AW-1:0] req_raddr,
   input  logic [NUM_REQ*DW-1:0] req_wdata,
   input  logic [NUM_REQ*3-1:0]  req_sel,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [NUM_REQ-1:0]    rvalid,
   output logic [DW-1:0]         rdata,
   output logic                  cwr,
   output logic                  crd,
   output logic [AW-1:0]         caddr_wr,
   output logic [AW-1:0]         caddr_rd,
   output logic [DW-1:0]         cdata_wr,
   output logic [2:0]            csel,
   input  logic [DW-1:0]         cdata_rd,
   output logic                  busy,
   output logic                  hold_err
);
   localparam int IW = $clog2(NUM_REQ);

   arb_state_t          state;
   logic [IW-1:0]       owner, last_owner, pick_last, win_idx;
   logic [NUM_REQ-1:0]  win, pick_req;
   logic                own_req, own_wr, own_rd, fwd, rel, force_rel;
   logic [1:0]          rd_vld;
   logic [1:0][IW-1:0]  rd_id;

   logic [AW-1:0] waddr_a [NUM_REQ];
   logic [AW-1:0] raddr_a [NUM_REQ];
   logic [DW-1:0] wdata_a [NUM_REQ];
   logic [2:0]    sel_a   [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
      assign waddr_a[g] = req_waddr[g*AW +: AW];
      assign raddr_a[g] = req_raddr[g*AW +: AW];
      assign wdata_a[g] = req_wdata[g*DW +: DW];
      assign sel_a[g]   = req_sel[g*3 +: 3];
   end

   assign own_req = req[owner];
   assign own_wr  = req_wr[owner];
   assign own_rd  = req_rd[owner];
   assign fwd     = (state == ARB_OWN) && own_req;
   assign rel     = (state == ARB_OWN) && (!own_req || force_rel);

   // One picker serves both IDLE arbitration and handover: while owning, the
   // search starts after the current owner, which is masked out.
   assign pick_last = (state == ARB_OWN) ? owner : last_owner;
   assign pick_req  = req & ~gnt;

   rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
      .req     (pick_req),
      .last    (pick_last),
      .win     (win),
      .win_idx (win_idx)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ARB_IDLE;
         gnt        <= '0;
         busy       <= 1'b0;
         owner      <= '0;
         last_owner <= IW'(NUM_REQ - 1);
         cwr        <= 1'b0;
         crd        <= 1'b0;
         caddr_wr   <= '0;
         caddr_rd   <= '0;
         cdata_wr   <= '0;
         csel       <= CSEL_NONE;
      end else begin
         cwr  <= fwd & own_wr;
         crd  <= fwd & own_rd;
         csel <= (fwd && (own_wr || own_rd)) ? sel_a[owner] : CSEL_NONE;
         if (fwd) begin
            caddr_wr <= waddr_a[owner];
            caddr_rd <= raddr_a[owner];
            cdata_wr <= wdata_a[owner];
         end
         if (state == ARB_IDLE) begin
            if (|req) begin
               gnt   <= win;
               busy  <= 1'b1;
               owner <= win_idx;
               state <= ARB_OWN;
            end
         end else if (rel) begin
            last_owner <= owner;
            if (|pick_req) begin
               gnt   <= win;
               owner <= win_idx;
            end else begin
               gnt   <= '0;
               busy  <= 1'b0;
               state <= ARB_IDLE;
            end
         end
      end
   end

   // Issuer id travels with the read so returns survive ownership changes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_vld <= '0;
         rd_id  <= '0;
         rdata  <= '0;
      end else begin
         rd_vld <= {rd_vld[0], fwd & own_rd};
         rd_id  <= {rd_id[0], owner};
         if (rd_vld[0]) rdata <= cdata_rd;
      end
   end

   always_comb begin
      rvalid = '0;
      rvalid[rd_id[1]] = rd_vld[1];
   end

`ifdef LAYER_MEM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(HOLD_MAX + 1);
   logic [CW-1:0] hold_cnt;

   // hold_cnt is the number of cycles the current grant has been visible
   assign force_rel = (state == ARB_OWN) && own_req &&
                      (hold_cnt >= CW'(HOLD_MAX)) && (|pick_req);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_cnt <= '0;
         hold_err <= 1'b0;
      end else begin
         hold_err <= force_rel;
         if (state == ARB_IDLE)
            hold_cnt <= (|req) ? CW'(1) : '0;
         else if (rel)
            hold_cnt <= (|pick_req) ? CW'(1) : '0;
         else if (hold_cnt < CW'(HOLD_MAX))
            hold_cnt <= hold_cnt + CW'(1);
      end
   end
`else
   localparam int hold_max_unused = HOLD_MAX;
   assign force_rel = 1'b0;
   assign hold_err  = 1'b0;
`endif
endmodule

// File: doc/layer_mem_arbiter.md
# layer_mem_arbiter

Round-robin arbiter that shares the single layer-memory port (`cwr`/`crd`/`caddr_wr`/`caddr_rd`/`cdata_wr`/`cdata_rd`/`csel`) among several engines. Typical requesters are the convolution writer, the max-pool reader/writer and a host readout path. A requester holds ownership for a burst. The arbiter forwards the owner's commands to the memory port through one register stage. Read data is routed back to the requester that issued the read, including after ownership has moved.

## Interface
- `NUM_REQ`, 3, number of requesters (2..8)
- `AW`, 12, memory address width
- `DW`, 20, memory data width
- `HOLD_MAX`, 4096, maximum grant length in cycles (used only with the timeout feature)
- `clk`  in  1  single clock, all logic on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req`  in  NUM_REQ  per-requester ownership request, level
- `req_wr`  in  NUM_REQ  write strobe, valid only for the current owner
- `req_rd`  in  NUM_REQ  read strobe, valid only for the current owner
- `req_waddr`, `req_raddr`  in  NUM_REQ*AW  packed write/read addresses
- `req_wdata`  in  NUM_REQ*DW  packed write data
- `req_sel`  in  NUM_REQ*3  packed memory select
- `gnt`  out  NUM_REQ  one-hot ownership, registered
- `rvalid`  out  NUM_REQ  one-hot read-return strobe
- `rdata`  out  DW  read data, shared by all requesters
- `cwr`, `crd`  out  1  memory write/read enables
- `caddr_wr`, `caddr_rd`  out  AW  memory addresses
- `cdata_wr`  out  DW  memory write data
- `csel`  out  3  memory select
- `cdata_rd`  in  DW  memory read data
- `busy`  out  1  high while any `gnt` bit is set
- `hold_err`  out  1  one-cycle pulse on a forced release (timeout feature only)

## Operation
- States: IDLE (no owner) and OWN (one owner).
- IDLE: if any `req` bit is high at a clock edge, the arbiter picks the winner round-robin.
  - The search starts at `last_owner+1` modulo NUM_REQ.
  - `last_owner` resets to NUM_REQ-1, so requester 0 wins first.
  - The winner's `gnt` bit sets and the state moves to OWN.
- OWN, owner `req` still high: each cycle the owner's `req_wr`/`req_rd`/addresses/`req_wdata`/`req_sel` are registered onto the memory port.
  - A write and a read in the same cycle are both forwarded.
  - `cwr` and `crd` are high for exactly the cycles the owner strobed them.
- OWN, owner `req` low at an edge:
  - The owner's `gnt` clears.
  - `last_owner` updates to that owner.
  - If another request is pending, the next winner's `gnt` sets at the same edge (zero-bubble handover). Otherwise the state returns to IDLE.
  - Strobes from a requester without `gnt` are ignored.
- `csel` drives 0 whenever `cwr` and `crd` are both low.
- Read tracking:
  - A 2-deep shift register carries {valid, requester id} for each forwarded read.
  - `rvalid[id]` pulses with `rdata` equal to the `cdata_rd` sampled one cycle after `crd`.
  - A read return is delivered even if the issuing requester has already released the grant.
- Reset, including mid-burst: `gnt`=0, `rvalid`=0, `rdata`=0, `cwr`=0, `crd`=0, `caddr_wr`=0, `caddr_rd`=0, `cdata_wr`=0, `csel`=0, `busy`=0, `hold_err`=0, state=IDLE. In-flight reads are discarded.

## Timing
- Request to grant: `req` high in cycle 0, `gnt` high in cycle 1.
- Command to memory: owner strobe in cycle C, memory port driven in cycle C+1.
- Read latency: `req_rd` in cycle C, `rvalid`/`rdata` in cycle C+2. Back-to-back reads give one return per cycle.
- Release to next grant:
  - 0 idle cycles when another requester is waiting.
  - 1 cycle from `req` rising to grant when the arbiter is IDLE.
- `busy` is registered together with `gnt`.

## Configuration
- `LAYER_MEM_ARB_TIMEOUT_EN` defined:
  - A hold counter counts cycles of the current grant.
  - The grant is forcibly released when the counter reaches `HOLD_MAX` and at least one other `req` bit is pending.
  - The release behaves as a normal handover. `hold_err` pulses for one cycle at that edge.
  - The counter clears on every grant change.
- Macro undefined: no counter. `hold_err` is tied to 0. Ownership lasts until the owner drops `req`.

## Structure
- Shared package `conv_pkg` holds:
  - `AW`/`DW` defaults.
  - Memory-select constants `CSEL_NONE`=3'b000, `CSEL_L0`=3'b001, `CSEL_L1`=3'b011.
  - The arbiter state enum.
- Sub-module `rr_picker` is combinational. Inputs: request vector and last owner. Outputs: one-hot winner and winner index.

## Test plan
- Single request: `req`=3'b001 in cycle 0 → `gnt`=3'b001 in cycle 1. Write addr 0x040, data 0x01310, csel 3'b001 in cycle 2 → `cwr`=1, `caddr_wr`=0x040, `cdata_wr`=0x01310, `csel`=3'b001 in cycle 3.
- Read return: owner 1 reads 0x3FF in cycle 5 with memory returning 0x0ABCD → `rvalid`=3'b010 and `rdata`=0x0ABCD in cycle 7. Owner 1 releases in cycle 6 → the return still goes to requester 1.
- Round-robin: all three `req` held high, each owner holding 4 cycles → grant order 0,1,2,0 with zero-bubble handovers.
- Ignored strobes: non-owner 2 pulses `req_wr` while 0 owns → `cwr` stays 0 in the following cycle.
- Reset: `reset` low mid-burst with a read in flight → all outputs 0 at once, and no `rvalid` after `reset` returns high.
- Timeout (macro on, `HOLD_MAX`=8): 0 holds `req` and 1 requests → `gnt` moves to 1 after 8 cycles with a `hold_err` pulse. With the macro off, 0 keeps `gnt` indefinitely.
